// File: rtl/factory_pio_pkg.sv
// factory_pio_pkg: register map addresses and edge-capture mode encodings shared by the PIO block
package factory_pio_pkg;
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/factory_pio_sync.sv
// factory_pio_sync: two-stage synchroniser (clk, reset, d -> q) for WIDTH asynchronous pins
module factory_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/factory_pio_v2.sv
// factory_pio_v2: bus-mapped PIO (DATA/DIR/IRQMASK/EDGECAP/OUTSET/OUTCLR) driving out_port/oe/irq from in_port
module factory_pio_v2 import factory_pio_pkg::*; #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int          EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  logic [WIDTH-1:0] data_q, dir_q, mask_q, cap_q, sync_q, prev_q, wd, det_raw, det, rd_val;
  logic [1:0] start_q;
  logic wr, rd, unused_wd;
  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;
  assign wd = writedata[WIDTH-1:0];
  assign unused_wd = ^(writedata >> WIDTH);
  assign out_port = data_q;
  assign oe = dir_q;
  factory_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_q)
  );
  always_comb begin
    det_raw = EDGE_TYPE == EDGE_FALLING ? ~sync_q & prev_q :
              EDGE_TYPE == EDGE_ANY     ? sync_q ^ prev_q  : sync_q & ~prev_q;
    det = start_q == 2'd3 ? det_raw : '0;
    rd_val = address == ADDR_DATA    ? (data_q & dir_q) | (sync_q & ~dir_q) :
             address == ADDR_DIR     ? dir_q  :
             address == ADDR_IRQMASK ? mask_q :
             address == ADDR_EDGECAP ? cap_q  : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE[WIDTH-1:0];
      dir_q    <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      prev_q   <= '0;
      start_q  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      prev_q   <= sync_q;
      start_q  <= start_q == 2'd3 ? start_q : start_q + 2'd1;
      irq      <= |(cap_q & mask_q);
      readdata <= rd ? 32'(rd_val) : '0;
      // a fresh edge wins over a same-cycle write-1-to-clear
      cap_q    <= (cap_q & ~(wr && address == ADDR_EDGECAP ? wd : '0)) | det;
      if (wr && address == ADDR_DATA) data_q <= wd;
      if (wr && address == ADDR_OUTSET) data_q <= data_q | wd;
      if (wr && address == ADDR_OUTCLR) data_q <= data_q & ~wd;
      if (wr && address == ADDR_DIR) dir_q <= wd;
      if (wr && address == ADDR_IRQMASK) mask_q <= wd;
    end
  end
endmodule
